// File: rtl/pipe_trace_pkg.sv
// pipe_trace_pkg: opcode/subop constants, trace FSM states and trace entry header shared by the trace unit.
package pipe_trace_pkg;
    localparam logic [4:0] OP_NOP    = 5'b00000;
    localparam logic [4:0] OP_HALT   = 5'b10000;
    localparam logic [4:0] OP_BEQ    = 5'b01100;
    localparam logic [4:0] OP_BNEQ   = 5'b01101;
    localparam logic [4:0] OP_JMP    = 5'b01110;
    localparam logic [4:0] OP_LD_STR = 5'b11111;
    localparam logic [1:0] SUB_LDB = 2'b00;
    localparam logic [1:0] SUB_STB = 2'b01;
    localparam logic [1:0] SUB_LDW = 2'b10;
    localparam logic [1:0] SUB_STW = 2'b11;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_STOPPED = 2'd2
    } trace_state_t;
    typedef struct packed {
        logic [4:0] opcode;
        logic [1:0] subop;
        logic       taken;
    } trace_hdr_t;
    function automatic logic is_branch(input logic [4:0] op);
        return op == OP_BEQ || op == OP_BNEQ || op == OP_JMP;
    endfunction
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous FIFO with wrap-bit pointers; a push into a full FIFO is accepted only alongside a pop.
module trace_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);
    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wp;
    logic [AW:0]  r_rp;
    logic         w_we;
    logic         w_re;
    assign level = r_wp - r_rp;
    assign empty = r_wp == r_rp;
    assign full  = level == (AW+1)'(DEPTH);
    assign w_re  = pop && !empty;
    assign w_we  = push && (!full || w_re);
    assign dout  = empty ? '0 : r_mem[r_rp[AW-1:0]];
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_we) r_wp <= r_wp + 1'b1;
            if (w_re) r_rp <= r_rp + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (w_we) r_mem[r_wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/pipe_trace_unit.sv
// pipe_trace_unit: snoops execute-stage instructions into a filtered trace FIFO, stopping on HALT.
// Defining TRACE_TIMESTAMP_EN stores a free-running cycle stamp with each entry on rd_time.
module pipe_trace_unit
    import pipe_trace_pkg::*;
#(
    parameter int INSTR_W = 27,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm,
    input  logic [31:0]              filter_mask,
    input  logic                     ex_valid,
    input  logic [INSTR_W-1:0]       ex_instr,
    input  logic [ADDR_W-1:0]        ex_pc,
    input  logic [DATA_W-1:0]        ex_result,
    input  logic                     br_taken,
    input  logic [ADDR_W-1:0]        br_target,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [ADDR_W-1:0]        rd_pc,
    output logic [4:0]               rd_opcode,
    output logic [1:0]               rd_subop,
    output logic                     rd_taken,
    output logic [DATA_W-1:0]        rd_data,
    output logic [CNT_W-1:0]         rd_time,
    output logic [1:0]               state,
    output logic                     halted,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         instr_count
);
`ifdef TRACE_TIMESTAMP_EN
    localparam int EW = ADDR_W + $bits(trace_hdr_t) + DATA_W + CNT_W;
    logic [CNT_W-1:0] r_ts;
`else
    localparam int EW = ADDR_W + $bits(trace_hdr_t) + DATA_W;
`endif
    trace_state_t r_state;
    logic         r_halted;
    logic         r_overflow;
    logic [CNT_W-1:0] r_count;
    logic [4:0]   w_op;
    logic [1:0]   w_sub;
    logic         w_taken;
    logic         w_cap;
    logic         w_qual;
    logic         w_pop;
    logic         w_push;
    logic         w_full;
    logic         w_empty;
    logic [DATA_W-1:0] w_data;
    logic [EW-1:0] w_din;
    logic [EW-1:0] w_dout;
    trace_hdr_t   w_hdr_in;
    trace_hdr_t   w_hdr_out;
    logic         w_unused_bits;
    assign w_op    = ex_instr[INSTR_W-1 -: 5];
    assign w_sub   = ex_instr[INSTR_W-6 -: 2];
    assign w_unused_bits = ^ex_instr[INSTR_W-8:0];
    assign w_taken = is_branch(w_op) && br_taken;
    assign w_data  = w_taken ? {{(DATA_W-ADDR_W){1'b0}}, br_target} : ex_result;
    // arm cycle discards the executing instruction
    assign w_cap   = r_state == ST_CAPTURE && ex_valid && !arm;
    assign w_qual  = w_cap && filter_mask[w_op];
    assign w_pop   = !w_empty && rd_ready;
    assign w_push  = w_qual && (!w_full || w_pop);
    assign w_hdr_in = '{opcode: w_op, subop: w_sub, taken: w_taken};
`ifdef TRACE_TIMESTAMP_EN
    assign w_din = {ex_pc, w_hdr_in, w_data, r_ts};
    assign {rd_pc, w_hdr_out, rd_data, rd_time} = w_dout;
    always_ff @(posedge clk) begin
        r_ts <= rst ? '0 : r_ts + 1'b1;
    end
`else
    assign w_din = {ex_pc, w_hdr_in, w_data};
    assign {rd_pc, w_hdr_out, rd_data} = w_dout;
    assign rd_time = '0;
`endif
    assign rd_opcode   = w_hdr_out.opcode;
    assign rd_subop    = w_hdr_out.subop;
    assign rd_taken    = w_hdr_out.taken;
    assign rd_valid    = !w_empty;
    assign state       = r_state;
    assign halted      = r_halted;
    assign overflow    = r_overflow;
    assign instr_count = r_count;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_halted   <= 1'b0;
            r_overflow <= 1'b0;
            r_count    <= '0;
        end else if (arm) begin
            r_state    <= ST_CAPTURE;
            r_halted   <= 1'b0;
            r_overflow <= 1'b0;
            r_count    <= '0;
        end else if (w_cap) begin
            if (~&r_count) r_count <= r_count + 1'b1;
            if (w_qual && !w_push) r_overflow <= 1'b1;
            if (w_op == OP_HALT) begin
                r_state  <= ST_STOPPED;
                r_halted <= 1'b1;
            end
        end
    end
    trace_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (arm),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_din),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .level (level)
    );
endmodule
